// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and the reset address.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fstate_t;

  localparam int unsigned RESET_ADDR = 0;

endpackage

// File: rtl/fetch_if.sv
// Request/acknowledge program memory read port.
// The fetch unit is the master, the memory is the slave.
interface fetch_if #(
  parameter int AW = 16
) ();

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of DEPTH 16-bit words with synchronous flush.
// Storage is not reset; only pointers and count are.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [15:0]                din,
  output logic [15:0]                dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: prefetches sequential words into a queue
// and presents the word at pc; any non-sequential pc flushes and refetches.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [AW-1:0] pc,
  input  logic          step,
  output logic [15:0]   ins,
  output logic          ins_valid,
  fetch_if.master       mem
);

  localparam int CW = $clog2(DEPTH + 1);

  fstate_t       fstate_q, fstate_d;
  logic [AW-1:0] head_addr_q, head_addr_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;

  logic [CW-1:0] count;
  logic [15:0]   head_data;
  logic          hit;
  logic          pop;
  logic          push;
  logic          redirect;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .clear (clear),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (mem.mem_data),
    .dout  (head_data),
    .count (count)
  );

  assign hit      = (count != '0) && (pc == head_addr_q);
  assign pop      = step && hit;
  assign redirect = (pc != head_addr_q) && !pop;

  assign ins_valid = hit;
  assign ins       = hit ? head_data : 16'h0000;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  always_comb begin
    fstate_d     = fstate_q;
    head_addr_d  = head_addr_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    push         = 1'b0;
    if (pop) head_addr_d = head_addr_q + 1'b1;
    if (redirect) begin
      head_addr_d  = pc;
      fetch_addr_d = pc;
    end
    unique case (fstate_q)
      IDLE: begin
        // A request is only issued with a free slot, so its ack always fits.
        if (!redirect && count < CW'(DEPTH)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr_q;
          fstate_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          fstate_d  = IDLE;
          if (!redirect) begin
            push         = 1'b1;
            fetch_addr_d = fetch_addr_q + 1'b1;
          end
        end else if (redirect) begin
          fstate_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          fstate_d  = IDLE;
        end
      end
      default: fstate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      fstate_q     <= IDLE;
      head_addr_q  <= AW'(RESET_ADDR);
      fetch_addr_q <= AW'(RESET_ADDR);
      mem_addr_q   <= AW'(RESET_ADDR);
      mem_req_q    <= 1'b0;
    end else begin
      fstate_q     <= fstate_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table, corner sequences and random
// pc streams checked against a memory-content model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        step = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [15:0] ins;
  logic        ins_valid;

  fetch_if #(.AW(16)) mif ();

  fetch_unit #(
    .DEPTH (4),
    .AW    (16)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .pc        (pc),
    .step      (step),
    .ins       (ins),
    .ins_valid (ins_valid),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 0;
  bit rand_lat = 1'b0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // memory: acks lat cycles after first seeing the request
  initial begin : mem_model
    int cnt;
    int cur;
    bit busy;
    cnt = 0;
    cur = 0;
    busy = 1'b0;
    mif.mem_ack = 1'b0;
    mif.mem_data = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (clear) begin
        mif.mem_ack = 1'b0;
        busy = 1'b0;
      end else if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        mif.mem_data = 16'hDEAD;
      end else if (mif.mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          cur = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end
        if (cnt == cur) begin
          mif.mem_ack = 1'b1;
          mif.mem_data = memf(mif.mem_addr);
          busy = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  logic [15:0] req_log[$];
  int stab_err = 0;
  int dbl = 0;

  initial begin : mon
    logic pr;
    logic [15:0] pa;
    bit busy;
    pr = 1'b0;
    pa = 16'h0;
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (clear) busy = 1'b0;
      if (mif.mem_req && !pr) begin
        if (busy) dbl++;
        busy = 1'b1;
        req_log.push_back(mif.mem_addr);
      end
      if (mif.mem_req && pr && mif.mem_addr != pa) stab_err++;
      if (mif.mem_ack) busy = 1'b0;
      pr = mif.mem_req;
      pa = mif.mem_addr;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] a);
    clear = 1'b1;
    pc = a;
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic fetch_one(input logic [15:0] a, input int hold,
                           input bit do_step);
    int n;
    n = 0;
    pc = a;
    step = 1'b0;
    #1;
    while (!ins_valid && n < 60) begin
      chk("ins_zero", 32'(ins), 32'(0));
      @(negedge clk);
      #1;
      n++;
    end
    chk("valid_in_time", 32'(ins_valid), 32'(1));
    chk($sformatf("ins@%h", a), 32'(ins), 32'(memf(a)));
    repeat (hold) begin
      @(negedge clk);
      #1;
    end
    if (do_step && ins_valid) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] pc;
    logic        step;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] ins;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] p, input logic s, input logic r,
                     input logic [15:0] ad, input logic v,
                     input logic [15:0] w);
    vec_t e;
    e.pc = p;
    e.step = s;
    e.req = r;
    e.addr = ad;
    e.valid = v;
    e.ins = w;
    tbl.push_back(e);
  endtask

  initial begin : main
    int mark;
    int n;
    logic [15:0] a;
    bit ds;
    int hold;

    // cold start, pc=0, 1-cycle memory; entry k is sampled after edge k
    add(16'd0, 0, 1, 16'd0, 0, 16'h0000);
    add(16'd0, 0, 0, 16'd0, 1, 16'hA000);
    add(16'd0, 0, 1, 16'd1, 1, 16'hA000);
    add(16'd0, 0, 0, 16'd1, 1, 16'hA000);
    add(16'd0, 0, 1, 16'd2, 1, 16'hA000);
    add(16'd0, 0, 0, 16'd2, 1, 16'hA000);
    add(16'd0, 0, 1, 16'd3, 1, 16'hA000);
    add(16'd0, 0, 0, 16'd3, 1, 16'hA000);
    add(16'd0, 0, 0, 16'd3, 1, 16'hA000);
    add(16'd0, 0, 0, 16'd3, 1, 16'hA000);
    add(16'd0, 1, 0, 16'd3, 1, 16'hA000);
    add(16'd1, 1, 0, 16'd3, 1, 16'hA001);
    add(16'd2, 1, 1, 16'd4, 1, 16'hA002);
    add(16'd3, 1, 0, 16'd4, 1, 16'hA003);
    add(16'd4, 1, 1, 16'd5, 1, 16'hA004);
    add(16'd5, 1, 0, 16'd5, 1, 16'hA005);
    add(16'd6, 0, 1, 16'd6, 0, 16'h0000);
    add(16'd6, 1, 0, 16'd6, 1, 16'hA006);
    add(16'd7, 0, 1, 16'd7, 0, 16'h0000);
    add(16'd7, 1, 0, 16'd7, 1, 16'hA007);
    add(16'd8, 0, 1, 16'd8, 0, 16'h0000);
    add(16'd8, 1, 0, 16'd8, 1, 16'hA008);
    add(16'd9, 0, 1, 16'd9, 0, 16'h0000);
    add(16'd9, 1, 0, 16'd9, 1, 16'hA009);
    add(16'd10, 0, 1, 16'd10, 0, 16'h0000);

    lat = 0;
    do_reset(16'h0000);
    #1;
    chk("rst_req", 32'(mif.mem_req), 32'(0));
    chk("rst_addr", 32'(mif.mem_addr), 32'(0));
    chk("rst_valid", 32'(ins_valid), 32'(0));
    chk("rst_ins", 32'(ins), 32'(0));

    foreach (tbl[i]) begin
      @(negedge clk);
      pc = tbl[i].pc;
      step = tbl[i].step;
      #1;
      chk($sformatf("v%0d_req", i), 32'(mif.mem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i), 32'(mif.mem_addr),
          32'(tbl[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(ins_valid),
          32'(tbl[i].valid));
      chk($sformatf("v%0d_ins", i), 32'(ins), 32'(tbl[i].ins));
    end
    step = 1'b0;

    // jump 2 -> 0x40 while the request for 2 is in flight
    lat = 3;
    do_reset(16'h0002);
    mark = req_log.size();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("jump_req", 32'(mif.mem_req), 32'(1));
    chk("jump_addr", 32'(mif.mem_addr), 32'(2));
    pc = 16'h0040;
    @(negedge clk);
    #1;
    chk("disc_req", 32'(mif.mem_req), 32'(1));
    chk("disc_addr", 32'(mif.mem_addr), 32'(2));
    fetch_one(16'h0040, 0, 1'b1);
    chk("jump_nreq", 32'(req_log.size() >= mark + 2), 32'(1));
    if (req_log.size() >= mark + 2) begin
      chk("jump_first", 32'(req_log[mark]), 32'h2);
      chk("jump_next", 32'(req_log[mark+1]), 32'h40);
    end

    // slow memory: ack sampled 5 cycles after the request
    lat = 4;
    do_reset(16'h0100);
    n = 0;
    #1;
    while (!ins_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("slow_latency", 32'(n), 32'(7));
    chk("slow_ins", 32'(ins), 32'hA100);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;

    // address wrap
    lat = 0;
    mark = req_log.size();
    fetch_one(16'hFFFE, 0, 1'b1);
    fetch_one(16'hFFFF, 0, 1'b1);
    fetch_one(16'h0000, 1, 1'b1);
    fetch_one(16'h0001, 0, 1'b1);
    chk("wrap_nreq", 32'(req_log.size() >= mark + 3), 32'(1));
    if (req_log.size() >= mark + 3) begin
      chk("wrap_r0", 32'(req_log[mark]), 32'hFFFE);
      chk("wrap_r1", 32'(req_log[mark+1]), 32'hFFFF);
      chk("wrap_r2", 32'(req_log[mark+2]), 32'h0000);
    end

    // random pc stream and memory latency
    rand_lat = 1'b1;
    a = 16'h1234;
    for (int k = 0; k < 300; k++) begin
      if (k != 0) begin
        if ($urandom_range(0, 4) == 0) begin
          if ($urandom_range(0, 1) == 1) a = 16'($urandom);
          else a = 16'hFFF0 | 16'($urandom_range(0, 15));
        end else begin
          a = a + 16'd1;
        end
      end
      ds = ($urandom_range(0, 9) != 0);
      hold = int'($urandom_range(0, 2));
      fetch_one(a, hold, ds);
    end

    // asynchronous reset while waiting with three words queued
    rand_lat = 1'b0;
    lat = 3;
    do_reset(16'h0000);
    mark = req_log.size();
    n = 0;
    while (req_log.size() < mark + 4 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("four_reqs", 32'(req_log.size() >= mark + 4), 32'(1));
    chk("pre_valid", 32'(ins_valid), 32'(1));
    chk("pre_req", 32'(mif.mem_req), 32'(1));
    clear = 1'b1;
    #1;
    chk("arst_req", 32'(mif.mem_req), 32'(0));
    chk("arst_addr", 32'(mif.mem_addr), 32'(0));
    chk("arst_valid", 32'(ins_valid), 32'(0));
    chk("arst_ins", 32'(ins), 32'(0));
    pc = 16'h0020;
    @(negedge clk);
    clear = 1'b0;
    mark = req_log.size();
    fetch_one(16'h0020, 0, 1'b1);
    fetch_one(16'h0021, 0, 1'b1);
    chk("arst_nreq", 32'(req_log.size() > mark), 32'(1));
    if (req_log.size() > mark) begin
      chk("arst_first", 32'(req_log[mark]), 32'h20);
    end

    chk("addr_stable", 32'(stab_err), 32'(0));
    chk("single_outstanding", 32'(dbl), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
